// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, counter sizing.
// Optional feature macro used by this block: MDU_MADD_EN (multiply-accumulate/subtract ops).
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MTHI  = 4'd4;
    localparam logic [3:0] MDU_MTLO  = 4'd5;
    localparam logic [3:0] MDU_MADD  = 4'd6;
    localparam logic [3:0] MDU_MADDU = 4'd7;
    localparam logic [3:0] MDU_MSUB  = 4'd8;
    localparam logic [3:0] MDU_MSUBU = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Counter must hold the larger of the two latencies.
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational product / quotient / remainder for the multiply/divide unit.
// MDU_MADD_EN adds the accumulate/subtract forms, which need the current {hi,lo}.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MDU_MADD_EN
    input  logic [2*WIDTH-1:0] hilo,
`endif
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic [2*WIDTH-1:0] prod_signed_s;
    logic [2*WIDTH-1:0] prod_unsigned_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   divisor_s;
    logic [WIDTH-1:0]   quo_mag_s;
    logic [WIDTH-1:0]   rem_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Low 2W bits of the sign-extended product equal the signed product.
    assign prod_signed_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_unsigned_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_by_zero = (b == {WIDTH{1'b0}});

    // Signed divide via magnitudes; most-negative / -1 falls out as quotient=most-negative, rem=0.
    always_comb begin
        a_neg_s   = (op == MDU_DIV) && a[WIDTH-1];
        b_neg_s   = (op == MDU_DIV) && b[WIDTH-1];
        a_mag_s   = a_neg_s ? (-a) : a;
        b_mag_s   = b_neg_s ? (-b) : b;
        divisor_s = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag_s;
        quo_mag_s = a_mag_s / divisor_s;
        rem_mag_s = a_mag_s % divisor_s;
        quo_s     = (a_neg_s ^ b_neg_s) ? (-quo_mag_s) : quo_mag_s;
        rem_s     = a_neg_s ? (-rem_mag_s) : rem_mag_s;
    end

    // Result select; HI is the upper half, LO the lower half.
    always_comb begin
        result = {(2*WIDTH){1'b0}};
        case (op)
            MDU_MULT:  result = prod_signed_s;
            MDU_MULTU: result = prod_unsigned_s;
            MDU_DIV,
            MDU_DIVU:  result = {rem_s, quo_s};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = hilo + prod_signed_s;
            MDU_MADDU: result = hilo + prod_unsigned_s;
            MDU_MSUB:  result = hilo - prod_signed_s;
            MDU_MSUBU: result = hilo - prod_unsigned_s;
`endif
            default:   result = {(2*WIDTH){1'b0}};
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: FSM, latency counter, result commit.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (op codes 6-9); otherwise they are no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e         state_r;
    mdu_state_e         state_s;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] pending_r;
    logic               dbz_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               mult_class_s;
    logic               div_class_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               accept_s;
    logic               commit_s;
    logic [2*WIDTH-1:0] dp_result_s;
    logic               dp_dbz_s;

    mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .op          (op),
        .a           (A),
        .b           (B),
`ifdef MDU_MADD_EN
        .hilo        ({hi_r, lo_r}),
`endif
        .result      (dp_result_s),
        .div_by_zero (dp_dbz_s)
    );

    // Op class decode.
    always_comb begin
        mult_class_s = 1'b0;
        div_class_s  = 1'b0;
        mthi_s       = 1'b0;
        mtlo_s       = 1'b0;
        case (op)
            MDU_MULT,
            MDU_MULTU: mult_class_s = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD,
            MDU_MADDU,
            MDU_MSUB,
            MDU_MSUBU: mult_class_s = 1'b1;
`endif
            MDU_DIV,
            MDU_DIVU:  div_class_s  = 1'b1;
            MDU_MTHI:  mthi_s       = 1'b1;
            MDU_MTLO:  mtlo_s       = 1'b1;
            default:   mult_class_s = 1'b0;
        endcase
    end

    // A start while busy is dropped entirely.
    assign accept_s = start && (state_r == IDLE);
    assign commit_s = (state_r == RUN) && (cnt_r == CW'(1));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (mult_class_s || div_class_s)) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (commit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latency counter, pending result and done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r     <= {CW{1'b0}};
            pending_r <= {(2*WIDTH){1'b0}};
            dbz_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (accept_s && mult_class_s) begin
                cnt_r     <= CW'(MULT_CYCLES);
                pending_r <= dp_result_s;
                dbz_r     <= 1'b0;
            end else if (accept_s && div_class_s) begin
                cnt_r     <= CW'(DIV_CYCLES);
                pending_r <= dp_result_s;
                dbz_r     <= dp_dbz_s;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // HI/LO: commit (skipped on divide by zero) or direct moves while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (commit_s) begin
            if (!dbz_r) begin
                hi_r <= pending_r[2*WIDTH-1:WIDTH];
                lo_r <= pending_r[WIDTH-1:0];
            end
        end else begin
            if (accept_s && mthi_s) begin
                hi_r <= A;
            end
            if (accept_s && mtlo_s) begin
                lo_r <= A;
            end
        end
    end

    assign busy = (state_r == RUN);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Sits beside the single-cycle ALU in the EX stage of the pipeline.
- Accepts one operation per start pulse, holds busy for a fixed latency per operation class, then commits results to HI/LO.
- The hazard unit stalls on busy, and on start, for any HI/LO consumer.

Parameters:
- WIDTH, 32: operand width and HI/LO register width.
- MULT_CYCLES, 5: busy cycles for multiply-class ops. Minimum 1.
- DIV_CYCLES, 10: busy cycles for divide-class ops. Minimum 1.

Ports:
- clk  input  1: single clock; all state updates on its rising edge.
- reset  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1: operation request, valid for one cycle.
- op  input  4: operation code (see Behaviour).
- A  input  WIDTH: operand rs.
- B  input  WIDTH: operand rt.
- busy  output  1: multi-cycle operation in flight.
- done  output  1: one-cycle pulse in the cycle HI/LO take the new result.
- hi  output  WIDTH: HI register.
- lo  output  WIDTH: LO register.

Behaviour:
- Op encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU. Codes 10-15 are no-ops (start accepted, nothing changes, no busy).
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, done=0, cycle counter=0, pending result discarded. This applies even mid-operation.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE, start with a mult-class op (0,1,6-9):
  - Operands are latched and the result is computed into a 2*WIDTH pending register.
  - Counter=MULT_CYCLES, go to RUN.
  - busy is 1 from the next cycle.
- IDLE, start with a div-class op (2,3): same, with counter=DIV_CYCLES.
- RUN: counter decrements each cycle. In the cycle the counter reaches 1:
  - next edge commits pending to {hi,lo};
  - done=1 for exactly that one cycle after the commit;
  - busy=0 in the same cycle as done;
  - state returns to IDLE.
- Total latency, start edge to HI/LO visible: MULT_CYCLES or DIV_CYCLES cycles.
- MTHI/MTLO in IDLE: hi (or lo) = A at the next edge. No busy, no done.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit must prevent it; the assertion bench flags it.
- MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi gets the upper half, lo the lower half.
- MULTU: unsigned WIDTH x WIDTH -> 2*WIDTH product; same split.
- DIV/DIVU results: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed most-negative / -1: lo=most-negative, hi=0.
  - Divide by zero (B==0): busy still runs DIV_CYCLES, hi/lo are left unchanged, done still pulses.
- Reset asserted with start in the same cycle: reset wins; the op is dropped.

Optional Feature:
- MDU_MADD_EN defined:
  - MADD/MADDU: {hi,lo} = {hi,lo} + A*B, signed/unsigned respectively.
  - MSUB/MSUBU: {hi,lo} = {hi,lo} - A*B.
  - Arithmetic is 2*WIDTH, wraps modulo 2^(2*WIDTH).
  - {hi,lo} is sampled at start.
  - MULT_CYCLES latency.
- MDU_MADD_EN undefined: codes 6-9 behave as no-ops, like codes 10-15.

Decomposition:
- Shared package mdu_pkg:
  - op code localparams (MDU_MULT ... MDU_MSUBU);
  - state encoding IDLE/RUN;
  - width helper for the counter, clog2 of max(MULT_CYCLES, DIV_CYCLES)+1.
- One natural sub-module, mdu_datapath: combinational product/quotient/remainder computation, including the signed-correction and divide-by-zero/overflow cases.
- The top module holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset then MULT with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
- MULTU with A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV with A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU with A=7, B=0 after MTHI A=0x11 and MTLO A=0x22 -> busy 10 cycles, done pulses, hi=0x11 and lo=0x22 unchanged.
- DIV started, then reset=0 on cycle 4 of busy -> next cycle busy=0, hi=lo=0, no done pulse.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU A=1, B=1 -> hi=1, lo=0. Without MDU_MADD_EN: same stimulus leaves hi/lo unchanged and busy stays 0.
